// File: rtl/mem_sched_pkg.sv
// Shared types for the data-memory port scheduler.
// FSM states, port source codes, route codes and default widths.
package mem_sched_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ISSUE,
    SPLIT,
    FORCE
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_L0,
    SRC_L1,
    SRC_LD
  } src_t;

  localparam logic ROUTE_A = 1'b0;
  localparam logic ROUTE_B = 1'b1;

endpackage

// File: rtl/data_mem_port_sched_if.sv
// Bundle of lane, loader, read-return and dual-port RAM signals.
// slave = scheduler side, master = core/loader/RAM side.
interface data_mem_port_sched_if
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              lane0_en;
  logic              lane0_we;
  logic [ADDR_W-1:0] lane0_addr;
  logic [DATA_W-1:0] lane0_wdata;
  logic              lane1_en;
  logic              lane1_we;
  logic [ADDR_W-1:0] lane1_addr;
  logic [DATA_W-1:0] lane1_wdata;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ready;
  logic              stall;
  logic              rd0_valid;
  logic [DATA_W-1:0] rd0_data;
  logic              rd1_valid;
  logic [DATA_W-1:0] rd1_data;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dia;
  logic [DATA_W-1:0] doa;
  logic              enb;
  logic              web;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] dib;
  logic [DATA_W-1:0] dob;

  modport slave (
    input  lane0_en, lane0_we, lane0_addr, lane0_wdata,
    input  lane1_en, lane1_we, lane1_addr, lane1_wdata,
    input  ld_valid, ld_addr, ld_wdata,
    input  doa, dob,
    output ld_ready, stall,
    output rd0_valid, rd0_data, rd1_valid, rd1_data,
    output ena, wea, addra, dia,
    output enb, web, addrb, dib
  );

  modport master (
    output lane0_en, lane0_we, lane0_addr, lane0_wdata,
    output lane1_en, lane1_we, lane1_addr, lane1_wdata,
    output ld_valid, ld_addr, ld_wdata,
    output doa, dob,
    input  ld_ready, stall,
    input  rd0_valid, rd0_data, rd1_valid, rd1_data,
    input  ena, wea, addra, dia,
    input  enb, web, addrb, dib
  );

endinterface

// File: rtl/mem_sched_conflict.sv
// Lane-pair conflict and loader address hazard detection.
// Pure combinational compare of lane and loader addresses.
module mem_sched_conflict
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_lane0_en,
  input  logic              i_lane0_we,
  input  logic [ADDR_W-1:0] i_lane0_addr,
  input  logic              i_lane1_en,
  input  logic              i_lane1_we,
  input  logic [ADDR_W-1:0] i_lane1_addr,
  input  logic [ADDR_W-1:0] i_ld_addr,
  output logic              o_conflict,
  output logic              o_ld_hz0,
  output logic              o_ld_hz1
);

  logic w_same;

  assign w_same     = i_lane0_addr == i_lane1_addr;
  // two loads to one address may share the cycle
  assign o_conflict = i_lane0_en & i_lane1_en & w_same
                    & (i_lane0_we | i_lane1_we);
  assign o_ld_hz0   = i_lane0_en & (i_ld_addr == i_lane0_addr);
  assign o_ld_hz1   = i_lane1_en & (i_ld_addr == i_lane1_addr);

endmodule

// File: rtl/data_mem_port_sched.sv
// Maps two VLIW memory lanes plus a loader onto RAM ports A/B.
// Serializes same-address pairs and forces starved loader writes.
module data_mem_port_sched
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  data_mem_port_sched_if.slave  bus
);

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  state_t            r_state;
  state_t            w_nxt;
  logic [7:0]        r_wait;
  logic              r_rd0_vld;
  logic              r_rd1_vld;
  logic              r_rd0_rt;
  logic              r_rd1_rt;

  src_t              w_srca;
  src_t              w_srcb;
  logic              w_stall;
  logic              w_conf;
  logic              w_hz0;
  logic              w_hz1;
  logic              w_force;
  logic              w_busy;
  logic              w_ld_rdy;
  logic              w_rd0_iss;
  logic              w_rd1_iss;
  logic              w_rt0;
  logic              w_rt1;

  logic              w_ena;
  logic              w_wea;
  logic [ADDR_W-1:0] w_addra;
  logic [DATA_W-1:0] w_dia;
  logic              w_enb;
  logic              w_web;
  logic [ADDR_W-1:0] w_addrb;
  logic [DATA_W-1:0] w_dib;

  mem_sched_conflict #(
    .ADDR_W (ADDR_W)
  ) u_conf (
    .i_lane0_en   (bus.lane0_en),
    .i_lane0_we   (bus.lane0_we),
    .i_lane0_addr (bus.lane0_addr),
    .i_lane1_en   (bus.lane1_en),
    .i_lane1_we   (bus.lane1_we),
    .i_lane1_addr (bus.lane1_addr),
    .i_ld_addr    (bus.ld_addr),
    .o_conflict   (w_conf),
    .o_ld_hz0     (w_hz0),
    .o_ld_hz1     (w_hz1)
  );

  assign w_force = (r_wait == WAIT_MAX) & bus.ld_valid;
  assign w_busy  = bus.lane0_en | bus.lane1_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ISSUE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_srca  = SRC_NONE;
    w_srcb  = SRC_NONE;
    w_stall = 1'b0;
    if (rstn) begin
      unique case (r_state)
        ISSUE: begin
          unique case (1'b1)
            w_force: begin
              w_srcb  = SRC_LD;
              w_stall = w_busy;
            end
            (!w_force && w_conf): begin
              w_srca  = SRC_L0;
              w_stall = 1'b1;
              w_nxt   = SPLIT;
              if (bus.ld_valid && !w_hz0) w_srcb = SRC_LD;
            end
            default: begin
              if (bus.lane0_en) w_srca = SRC_L0;
              if (bus.lane1_en) w_srcb = SRC_L1;
              if (bus.ld_valid && !w_hz0 && !w_hz1) begin
                if (!bus.lane1_en)      w_srcb = SRC_LD;
                else if (!bus.lane0_en) w_srca = SRC_LD;
              end
            end
          endcase
        end
        SPLIT: begin
          if (bus.lane1_en) w_srca = SRC_L1;
          if (bus.ld_valid && !w_hz1) w_srcb = SRC_LD;
          // a blocked force is retried in a dedicated cycle
          w_nxt = (w_force && w_hz1) ? FORCE : ISSUE;
        end
        FORCE: begin
          if (bus.ld_valid) w_srcb = SRC_LD;
          w_stall = w_busy;
          w_nxt   = ISSUE;
        end
        default: w_nxt = ISSUE;
      endcase
    end
  end

  always_comb begin
    w_ena   = 1'b0;
    w_wea   = 1'b0;
    w_addra = '0;
    w_dia   = '0;
    unique case (w_srca)
      SRC_L0: begin
        w_ena   = 1'b1;
        w_wea   = bus.lane0_we;
        w_addra = bus.lane0_addr;
        w_dia   = bus.lane0_wdata;
      end
      SRC_L1: begin
        w_ena   = 1'b1;
        w_wea   = bus.lane1_we;
        w_addra = bus.lane1_addr;
        w_dia   = bus.lane1_wdata;
      end
      SRC_LD: begin
        w_ena   = 1'b1;
        w_wea   = 1'b1;
        w_addra = bus.ld_addr;
        w_dia   = bus.ld_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_enb   = 1'b0;
    w_web   = 1'b0;
    w_addrb = '0;
    w_dib   = '0;
    unique case (w_srcb)
      SRC_L1: begin
        w_enb   = 1'b1;
        w_web   = bus.lane1_we;
        w_addrb = bus.lane1_addr;
        w_dib   = bus.lane1_wdata;
      end
      SRC_LD: begin
        w_enb   = 1'b1;
        w_web   = 1'b1;
        w_addrb = bus.ld_addr;
        w_dib   = bus.ld_wdata;
      end
      default: ;
    endcase
  end

  assign w_ld_rdy  = (w_srca == SRC_LD) | (w_srcb == SRC_LD);
  assign w_rd0_iss = (w_srca == SRC_L0) & ~bus.lane0_we;
  assign w_rd1_iss = ((w_srca == SRC_L1) | (w_srcb == SRC_L1))
                   & ~bus.lane1_we;
  assign w_rt0     = (w_srcb == SRC_L0) ? ROUTE_B : ROUTE_A;
  assign w_rt1     = (w_srcb == SRC_L1) ? ROUTE_B : ROUTE_A;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wait <= '0;
    end else if (!bus.ld_valid || w_ld_rdy) begin
      r_wait <= '0;
    end else if (r_wait != WAIT_MAX) begin
      r_wait <= r_wait + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd0_vld <= 1'b0;
      r_rd1_vld <= 1'b0;
      r_rd0_rt  <= ROUTE_A;
      r_rd1_rt  <= ROUTE_A;
    end else begin
      r_rd0_vld <= w_rd0_iss;
      r_rd1_vld <= w_rd1_iss;
      r_rd0_rt  <= w_rt0;
      r_rd1_rt  <= w_rt1;
    end
  end

  assign bus.ena       = w_ena;
  assign bus.wea       = w_wea;
  assign bus.addra     = w_addra;
  assign bus.dia       = w_dia;
  assign bus.enb       = w_enb;
  assign bus.web       = w_web;
  assign bus.addrb     = w_addrb;
  assign bus.dib       = w_dib;
  assign bus.stall     = w_stall;
  assign bus.ld_ready  = w_ld_rdy;
  assign bus.rd0_valid = r_rd0_vld;
  assign bus.rd1_valid = r_rd1_vld;
  assign bus.rd0_data  = (r_rd0_rt == ROUTE_B) ? bus.dob : bus.doa;
  assign bus.rd1_data  = (r_rd1_rt == ROUTE_B) ? bus.dob : bus.doa;

endmodule

// File: tb/tb_data_mem_port_sched.sv
// Bench for data_mem_port_sched: directed cases plus random traffic
// checked against a program-order memory model.
module tb_data_mem_port_sched;
  import mem_sched_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MW    = 3;
  localparam int MEMSZ = 512;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ram_load = 1'b1;

  always #5 clk = ~clk;

  data_mem_port_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_port_sched #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 ^ 32'(i * 7919);
  endfunction

  logic [DW-1:0] ram [MEMSZ];

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < MEMSZ; i++) ram[i] <= init_val(i);
    end else begin
      if (bus.ena) begin
        if (bus.wea) ram[bus.addra[8:0]] <= bus.dia;
        bus.doa <= ram[bus.addra[8:0]];
      end
      if (bus.enb) begin
        if (bus.web) ram[bus.addrb[8:0]] <= bus.dib;
        bus.dob <= ram[bus.addrb[8:0]];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] gmem [MEMSZ];
  logic [DW-1:0] exp0_q [$];
  logic [DW-1:0] exp1_q [$];
  int ld_wait = 0;
  int stall_run = 0;

  task automatic model_cycle();
    chk("dual_wr", bus.ena & bus.wea & bus.enb & bus.web
        & (bus.addra == bus.addrb), 1'b0);
    if (!bus.stall) begin
      if (bus.lane0_en | bus.lane1_en)
        chk("stall_run", stall_run <= 2, 1'b1);
      stall_run = 0;
      if (bus.lane0_en) begin
        if (!bus.lane0_we) exp0_q.push_back(gmem[bus.lane0_addr[8:0]]);
        else gmem[bus.lane0_addr[8:0]] = bus.lane0_wdata;
      end
      if (bus.lane1_en) begin
        if (!bus.lane1_we) exp1_q.push_back(gmem[bus.lane1_addr[8:0]]);
        else gmem[bus.lane1_addr[8:0]] = bus.lane1_wdata;
      end
    end else begin
      stall_run++;
    end
    if (bus.ld_ready) begin
      chk("ld_wait", ld_wait <= MW + 1, 1'b1);
      gmem[bus.ld_addr[8:0]] = bus.ld_wdata;
      ld_wait = 0;
    end else if (bus.ld_valid) begin
      ld_wait++;
    end else begin
      ld_wait = 0;
    end
    if (bus.rd0_valid) begin
      if (exp0_q.size() == 0) chk("rd0_spurious", 1'b1, 1'b0);
      else chk("rd0_data", bus.rd0_data, exp0_q.pop_front());
    end
    if (bus.rd1_valid) begin
      if (exp1_q.size() == 0) chk("rd1_spurious", 1'b1, 1'b0);
      else chk("rd1_data", bus.rd1_data, exp1_q.pop_front());
    end
  endtask

  task automatic nedge();
    @(negedge clk);
    if (rstn) model_cycle();
  endtask

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  task automatic lanes(input logic e0, input logic w0,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic e1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1);
    bus.lane0_en    = e0;
    bus.lane0_we    = w0;
    bus.lane0_addr  = a0;
    bus.lane0_wdata = d0;
    bus.lane1_en    = e1;
    bus.lane1_we    = w1;
    bus.lane1_addr  = a1;
    bus.lane1_wdata = d1;
  endtask

  task automatic ld(input logic v, input logic [31:0] a,
                    input logic [31:0] d);
    bus.ld_valid = v;
    bus.ld_addr  = a;
    bus.ld_wdata = d;
  endtask

  task automatic idle();
    lanes(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic adv;
  logic took;
  int   nbad_mem;

  initial begin
    for (int i = 0; i < MEMSZ; i++) gmem[i] = init_val(i);
    lanes(1, 0, 5, 0, 1, 1, 6, 7);
    ld(1, 'h100, 'h55);

    // reset behaviour with active requests
    @(negedge clk);
    chk("rst_ena", bus.ena, 1'b0);
    chk("rst_enb", bus.enb, 1'b0);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_ldrdy", bus.ld_ready, 1'b0);
    chk("rst_rdv", {bus.rd0_valid, bus.rd1_valid}, 2'b00);
    pedge();
    ram_load = 1'b0;
    idle();
    ld(0, 0, 0);
    rstn = 1'b1;
    nedge();
    chk("idle_stall", bus.stall, 1'b0);
    pedge();

    // parallel load/store
    lanes(1, 0, 'h10, 0, 1, 1, 'h20, 'hDEAD);
    nedge();
    chk("d1_porta", {bus.ena, bus.wea, bus.addra}, {1'b1, 1'b0, 32'h10});
    chk("d1_portb", {bus.enb, bus.web, bus.addrb}, {1'b1, 1'b1, 32'h20});
    chk("d1_dib", bus.dib, 32'hDEAD);
    chk("d1_stall", bus.stall, 1'b0);
    pedge();
    idle();
    nedge();
    chk("d1_rdv", {bus.rd0_valid, bus.rd1_valid}, 2'b10);
    chk("d1_rd0", bus.rd0_data, init_val('h10));
    pedge();

    // store then load, same address
    lanes(1, 1, 'h40, 'h1111, 1, 0, 'h40, 0);
    nedge();
    chk("d2_t0_a", {bus.ena, bus.wea, bus.addra}, {1'b1, 1'b1, 32'h40});
    chk("d2_t0_stall", bus.stall, 1'b1);
    pedge();
    nedge();
    chk("d2_t1_a", {bus.ena, bus.wea, bus.addra}, {1'b1, 1'b0, 32'h40});
    chk("d2_t1_stall", bus.stall, 1'b0);
    chk("d2_t1_rdv", {bus.rd0_valid, bus.rd1_valid}, 2'b00);
    pedge();
    idle();
    nedge();
    chk("d2_t2_rdv", {bus.rd0_valid, bus.rd1_valid}, 2'b01);
    chk("d2_t2_rd1", bus.rd1_data, 32'h1111);
    pedge();

    // write/write, lane1 wins
    lanes(1, 1, 'h80, 'hA, 1, 1, 'h80, 'hB);
    nedge();
    chk("d3_t0_stall", bus.stall, 1'b1);
    pedge();
    nedge();
    chk("d3_t1_stall", bus.stall, 1'b0);
    chk("d3_t1_a", {bus.ena, bus.wea, bus.addra}, {1'b1, 1'b1, 32'h80});
    pedge();
    idle();
    nedge();
    pedge();
    chk("d3_ram", ram['h80], 32'hB);

    // loader on idle port B
    ld(1, 'h120, 'h77);
    nedge();
    chk("d4_ldrdy", bus.ld_ready, 1'b1);
    chk("d4_portb", {bus.enb, bus.web, bus.addrb}, {1'b1, 1'b1, 32'h120});
    chk("d4_ena", bus.ena, 1'b0);
    pedge();
    ld(0, 0, 0);

    // starvation: grant forced on 4th busy cycle, twice
    for (int r = 0; r < 2; r++) begin
      ld(1, 32'h121 + 32'(r), 32'h99 + 32'(r));
      for (int k = 1; k <= 4; k++) begin
        if (!(r == 1 && k == 1))
          lanes(1, 1, 32'(k), $urandom, 1, 1, 32'(k + 8), $urandom);
        nedge();
        if (k < 4) begin
          chk("d5_wait_rdy", bus.ld_ready, 1'b0);
          chk("d5_wait_stall", bus.stall, 1'b0);
        end else begin
          chk("d5_force_rdy", bus.ld_ready, 1'b1);
          chk("d5_force_stall", bus.stall, 1'b1);
          chk("d5_force_ena", bus.ena, 1'b0);
          chk("d5_force_b", {bus.enb, bus.addrb},
              {1'b1, 32'h121 + 32'(r)});
        end
        pedge();
      end
    end
    ld(0, 0, 0);
    nedge();
    chk("d5_after_stall", bus.stall, 1'b0);
    pedge();

    // same-address loads run in parallel
    lanes(1, 0, 'h30, 0, 1, 0, 'h30, 0);
    nedge();
    chk("d6_stall", bus.stall, 1'b0);
    chk("d6_ens", {bus.ena, bus.enb}, 2'b11);
    pedge();
    idle();
    nedge();
    chk("d6_rdv", {bus.rd0_valid, bus.rd1_valid}, 2'b11);
    chk("d6_eq", bus.rd0_data == bus.rd1_data, 1'b1);
    chk("d6_rd0", bus.rd0_data, init_val('h30));
    pedge();

    // loader blocked by matching lane address
    lanes(1, 1, 'h50, 'h5, 0, 0, 0, 0);
    ld(1, 'h50, 'h6);
    nedge();
    chk("d7_hz_rdy", bus.ld_ready, 1'b0);
    pedge();
    idle();
    nedge();
    chk("d7_free_rdy", bus.ld_ready, 1'b1);
    pedge();
    ld(0, 0, 0);

    // reset during SPLIT
    lanes(1, 0, 'h70, 0, 1, 1, 'h70, 'h7);
    nedge();
    chk("d8_stall", bus.stall, 1'b1);
    pedge();
    rstn = 1'b0;
    #1;
    chk("d8_rst_ena", bus.ena, 1'b0);
    chk("d8_rst_enb", bus.enb, 1'b0);
    idle();
    pedge();
    rstn = 1'b1;
    exp0_q.delete();
    exp1_q.delete();
    stall_run = 0;
    ld_wait = 0;
    nedge();
    chk("d8_rdv", {bus.rd0_valid, bus.rd1_valid}, 2'b00);
    chk("d8_stall_idle", bus.stall, 1'b0);
    pedge();
    lanes(1, 1, 'h71, 'h1, 1, 1, 'h72, 'h2);
    nedge();
    chk("d8_issue_stall", bus.stall, 1'b0);
    chk("d8_issue_a", {bus.ena, bus.addra}, {1'b1, 32'h71});
    chk("d8_issue_b", {bus.enb, bus.addrb}, {1'b1, 32'h72});
    pedge();
    idle();

    // random traffic
    adv  = 1'b1;
    took = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (adv)
        lanes($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 7)), $urandom);
      if (!bus.ld_valid || took)
        ld(1'($urandom_range(0, 1)),
           32'h100 + 32'($urandom_range(0, 63)), $urandom);
      nedge();
      adv  = !bus.stall;
      took = bus.ld_ready;
      pedge();
    end

    idle();
    ld(0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      nedge();
      pedge();
    end
    chk("exp0_left", exp0_q.size(), 0);
    chk("exp1_left", exp1_q.size(), 0);
    nbad_mem = 0;
    for (int i = 0; i < MEMSZ; i++)
      if (ram[i] !== gmem[i]) nbad_mem++;
    chk("mem_image", nbad_mem, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_port_sched.md
Name: data_mem_port_sched

Overview:
Schedules the two VLIW memory slots (lane0, lane1) and the boot/IO loader write channel onto the two ports (A, B) of the dual-write data memory. Non-conflicting lane pairs issue in parallel. Same-address pairs are serialized in program order, and the core is stalled for the split.
- Loader writes use idle ports; a starvation counter forces one loader slot when needed.
- Returned read data is routed back to the issuing lane.

Parameters:
ADDR_W, 32, word-address width of all address ports.
DATA_W, 32, data width.
MAX_WAIT, 8, number of cycles a pending loader write waits before forcing a slot; range 1..255.

Ports:
clk  in  1  single clock; drives the scheduler and both RAM ports (clka = clkb = clk).
rstn  in  1  reset, asynchronous, active-low.
lane0_en  in  1  slot 0 memory request; held stable by the core while stall=1.
lane0_we  in  1  1 = store, 0 = load.
lane0_addr  in  ADDR_W  slot 0 word address.
lane0_wdata  in  DATA_W  slot 0 store data.
lane1_en, lane1_we, lane1_addr, lane1_wdata  in  1/1/ADDR_W/DATA_W  slot 1; same meaning as slot 0; later in program order.
ld_valid  in  1  loader write pending.
ld_addr  in  ADDR_W  loader write address.
ld_wdata  in  DATA_W  loader write data.
ld_ready  out  1  loader write accepted this cycle.
stall  out  1  core must hold the current bundle.
rd0_valid, rd0_data  out  1/DATA_W  load result for slot 0.
rd1_valid, rd1_data  out  1/DATA_W  load result for slot 1.
ena, wea, addra, dia  out  1/1/ADDR_W/DATA_W  RAM port A controls.
doa  in  DATA_W  RAM port A read data; registered, 1-cycle latency.
enb, web, addrb, dib  out  1/1/ADDR_W/DATA_W  RAM port B controls.
dob  in  DATA_W  RAM port B read data.

Behaviour:
- Reset (async): state=ISSUE, wait_cnt=0, rd0_valid=rd1_valid=0, route flops=0. While rstn=0: ena=enb=wea=web=0, stall=0, ld_ready=0.
- Conflict: lane0_en & lane1_en & (addr0==addr1) & (we0|we1). Two same-address loads are not a conflict.
- FSM states: ISSUE, SPLIT, FORCE. Port outputs, stall and ld_ready are combinational from state and inputs.
- ISSUE, force condition (wait_cnt==MAX_WAIT & ld_valid):
  - Loader gets port B, ld_ready=1. Lanes get no port.
  - stall = lane0_en|lane1_en. Next state = ISSUE.
  - The FORCE state is not used for this; it is entered only when a force is deferred out of SPLIT.
- ISSUE, no force, conflict:
  - lane0 issues on port A; stall=1; next state = SPLIT.
  - The loader may use port B in this cycle.
- ISSUE, no force, no conflict:
  - lane0 → A, lane1 → B; stall=0.
  - The loader takes a free port, preferring B, else A.
- SPLIT:
  - lane1 issues on port A; lane0 is ignored (already served); stall=0; next state = ISSUE.
  - A loader write may use port B only if ld_addr != lane1_addr.
  - If force is due in SPLIT, next state = FORCE.
- FORCE: identical to the ISSUE force cycle, then return to ISSUE.
- Loader hazard in ISSUE: a loader write is not granted in a cycle where ld_addr equals an issuing lane address. It waits.
- wait_cnt:
  - Cleared on ld_ready.
  - Incremented while ld_valid & !ld_ready, saturating at MAX_WAIT.
  - Held at 0 while ld_valid=0.
- Read return:
  - A lane load issued at cycle t sets rdN_valid=1 at t+1.
  - rdN_data = doa or dob per the route flop captured at t.
  - Stores and loader writes produce no valid.
  - Serialized pair: rd0 at t+1, rd1 at t+2.
- Port B is never driven by lane0; port A is never driven by the loader except in a no-conflict ISSUE cycle where lane0 is idle.
- Ordering guarantees:
  - Same-address write/write: lane1's value persists.
  - lane0 store then lane1 load: lane1 reads the new value.
  - lane0 load then lane1 store: lane0 reads the old value.
- Reset mid-SPLIT or mid-FORCE: return to ISSUE, pending valids dropped, no port enabled.

Decomposition:
- Shared package mem_sched_pkg:
  - state enum (ISSUE, SPLIT, FORCE)
  - port route encoding (ROUTE_A=0, ROUTE_B=1)
  - default ADDR_W/DATA_W
- One natural sub-module: mem_sched_conflict, a combinational conflict/hazard detector over the lane and loader addresses.
- The FSM, counter and read routing stay in the top module.

Test Plan:
- lane0 load 0x10, lane1 store 0x20=0xDEAD, no loader → same cycle A=rd 0x10, B=wr 0x20; stall=0; rd0_valid next cycle with ram[0x10].
- lane0 store 0x40=0x1111, lane1 load 0x40 → cycle t: A wr, stall=1; t+1: A rd 0x40; rd1_data=0x1111 at t+2; no rd0_valid.
- Both lanes store to 0x80 (0xA, 0xB) → two cycles, stall one cycle; final ram[0x80]=0xB.
- ld_valid with lanes idle → ld_ready same cycle on port B; with MAX_WAIT=3 and both lanes busy every cycle → forced grant on the 4th cycle, stall=1 that cycle, wait_cnt returns to 0.
- Two loads to the same address 0x30 → parallel, no stall, both rd valids next cycle with equal data.
- Deassert rstn during SPLIT → ena=enb=0 immediately; after release state=ISSUE, rd valids 0, stall=0 with idle lanes.
